// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// saturating count of valid fetches, with branch redirect and decode stall.
module fetch_stage #(
  parameter int          IMEM_DEPTH = 128,
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_ENC    = 16'hBF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_instr,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc,
  output logic        ifid_valid,
  output logic [15:0] fetch_count
);

  // IMEM_DEPTH is a power of two, so modulo reduces to a mask.
  localparam logic [15:0] PC_MASK = 16'(IMEM_DEPTH - 1);

  logic [15:0] pc;

  // imem_addr depends only on the PC register, never on stall or redirect.
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC & PC_MASK;
      ifid_instr  <= NOP_ENC;
      ifid_pc     <= 16'h0000;
      ifid_valid  <= 1'b0;
      fetch_count <= 16'h0000;
    end else if (redirect_valid) begin
      // The instruction fetched this cycle is on the wrong path: squash it.
      pc          <= redirect_target & PC_MASK;
      ifid_instr  <= NOP_ENC;
      ifid_pc     <= 16'h0000;
      ifid_valid  <= 1'b0;
    end else if (!stall) begin
      pc          <= (pc + 16'd1) & PC_MASK;
      ifid_instr  <= imem_instr;
      ifid_pc     <= pc;
      ifid_valid  <= 1'b1;
      if (fetch_count != 16'hFFFF) begin
        fetch_count <= fetch_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage: a directed vector table with
// hand-computed results, plus short sequences for multi-cycle corner cases.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic        ifid_valid;
  logic [15:0] fetch_count;

  logic [15:0] mem [128];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rdv;
    logic [15:0] tgt;
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        valid;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  // Instruction memory model: mem[i] = 16'h1000 + i.
  assign imem_instr = mem[imem_addr[6:0]];

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .ifid_instr      (ifid_instr),
    .ifid_pc         (ifid_pc),
    .ifid_valid      (ifid_valid),
    .fetch_count     (fetch_count)
  );

  task automatic add_vec(input logic r, input logic s, input logic d,
                         input logic [15:0] t, input logic [15:0] a,
                         input logic [15:0] i, input logic [15:0] p,
                         input logic v, input logic [15:0] c);
    vec_t x;
    x.rst = r; x.stl = s; x.rdv = d; x.tgt = t;
    x.addr = a; x.instr = i; x.pc = p; x.valid = v; x.cnt = c;
    vecs.push_back(x);
  endtask

  // Free-running edges from PC=first, fetch_count=cnt0 before the first edge.
  task automatic add_free(input int first, input int n, input int cnt0);
    for (int k = 0; k < n; k++) begin
      add_vec(0, 0, 0, 16'h0000, 16'((first + k + 1) % 128),
              16'(16'h1000 + first + k), 16'(first + k), 1,
              16'(cnt0 + k + 1));
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic d,
                               input logic [15:0] t);
    reset           = r;
    stall           = s;
    redirect_valid  = d;
    redirect_target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] a,
                           input logic [15:0] i, input logic [15:0] p,
                           input logic v, input logic [15:0] c);
    checkOutput({tag, " imem_addr"}, imem_addr, a);
    checkOutput({tag, " ifid_instr"}, ifid_instr, i);
    checkOutput({tag, " ifid_pc"}, ifid_pc, p);
    checkOutput({tag, " ifid_valid"}, {15'b0, ifid_valid}, {15'b0, v});
    checkOutput({tag, " fetch_count"}, fetch_count, c);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'(16'h1000 + i);
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 16'h0000;

    // Reset, then five free edges.
    add_vec(1, 0, 0, 16'h0000, 16'd0, 16'hBF00, 16'd0, 0, 16'd0);
    add_free(0, 5, 0);
    // Reset, three free edges, stall three edges at PC=3, release.
    add_vec(1, 0, 0, 16'h0000, 16'd0, 16'hBF00, 16'd0, 0, 16'd0);
    add_free(0, 3, 0);
    for (int k = 0; k < 3; k++)
      add_vec(0, 1, 0, 16'h0000, 16'd3, 16'h1002, 16'd2, 1, 16'd3);
    add_free(3, 1, 3);
    // Run to PC=11, redirect to 4; one bubble, then target instruction.
    add_free(4, 7, 4);
    add_vec(0, 0, 1, 16'd4, 16'd4, 16'hBF00, 16'd0, 0, 16'd11);
    add_vec(0, 0, 0, 16'h0000, 16'd5, 16'h1004, 16'd4, 1, 16'd12);
    // Redirect together with stall: redirect wins.
    add_vec(0, 1, 1, 16'd21, 16'd21, 16'hBF00, 16'd0, 0, 16'd12);
    add_vec(0, 0, 0, 16'h0000, 16'd22, 16'h1015, 16'd21, 1, 16'd13);
    // Wrap from 127 to 0, and a redirect target reduced modulo 128.
    add_vec(0, 0, 1, 16'd127, 16'd127, 16'hBF00, 16'd0, 0, 16'd13);
    add_vec(0, 0, 0, 16'h0000, 16'd0, 16'h107F, 16'd127, 1, 16'd14);
    add_vec(0, 0, 1, 16'h0085, 16'd5, 16'hBF00, 16'd0, 0, 16'd14);
    add_vec(0, 0, 0, 16'h0000, 16'd6, 16'h1005, 16'd5, 1, 16'd15);
    // Reach PC=9 with fetch_count=7, stall, then reset during stall+redirect.
    add_vec(1, 0, 0, 16'h0000, 16'd0, 16'hBF00, 16'd0, 0, 16'd0);
    add_free(0, 7, 0);
    add_vec(0, 0, 1, 16'd9, 16'd9, 16'hBF00, 16'd0, 0, 16'd7);
    add_vec(0, 1, 0, 16'h0000, 16'd9, 16'hBF00, 16'd0, 0, 16'd7);
    add_vec(1, 1, 1, 16'd50, 16'd0, 16'hBF00, 16'd0, 0, 16'd0);
    add_vec(0, 0, 0, 16'h0000, 16'd1, 16'h1000, 16'd0, 1, 16'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].stl, vecs[i].rdv, vecs[i].tgt);
      check_all($sformatf("v%0d", i), vecs[i].addr, vecs[i].instr,
                vecs[i].pc, vecs[i].valid, vecs[i].cnt);
    end

    // imem_addr must not react combinationally to stall or redirect (PC=1).
    stall = 1'b1;
    #1 checkOutput("comb stall imem_addr", imem_addr, 16'd1);
    redirect_valid = 1'b1; redirect_target = 16'd77;
    #1 checkOutput("comb redirect imem_addr", imem_addr, 16'd1);

    // Reset asserted together with a redirect leaves no trace of it.
    applyStimulus(1, 0, 1, 16'd30);
    check_all("rst_redir", 16'd0, 16'hBF00, 16'd0, 0, 16'd0);
    applyStimulus(1, 0, 0, 16'h0000);
    check_all("rst_hold", 16'd0, 16'hBF00, 16'd0, 0, 16'd0);
    applyStimulus(0, 0, 0, 16'h0000);
    check_all("post_rst", 16'd1, 16'h1000, 16'd0, 1, 16'd1);

    // Stall on top of a bubble keeps the bubble and the count.
    applyStimulus(0, 0, 1, 16'd126);
    applyStimulus(0, 1, 0, 16'h0000);
    check_all("stall_bubble", 16'd126, 16'hBF00, 16'd0, 0, 16'd1);
    applyStimulus(0, 0, 0, 16'h0000);
    applyStimulus(0, 0, 0, 16'h0000);
    check_all("wrap_seq", 16'd0, 16'h107F, 16'd127, 1, 16'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
